// File: rtl/zero_count_pkg.sv
// Shared types and constants for the multi-cycle zero counter.
package zero_count_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  localparam logic MODE_TRAIL = 1'b0;
  localparam logic MODE_LEAD  = 1'b1;

endpackage

// File: rtl/chunk_zero_count.sv
// Combinational zero count within one CHUNK-bit slice, trailing or leading.
module chunk_zero_count
  import zero_count_pkg::*;
#(
  parameter  int CHUNK = 8,
  localparam int LCW   = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] chunk,
  input  logic             mode,
  output logic             found,
  output logic [LCW-1:0]   zcount
);

  // Later loop iterations win, so each loop walks towards the bit that must take priority.
  always_comb begin
    found  = |chunk;
    zcount = LCW'(CHUNK);
    if (mode == MODE_TRAIL) begin
      for (int unsigned i = 0; i < CHUNK; i++) begin
        if (chunk[CHUNK-1-i]) zcount = LCW'(CHUNK - 1 - i);
      end
    end else begin
      for (int unsigned i = 0; i < CHUNK; i++) begin
        if (chunk[i]) zcount = LCW'(CHUNK - 1 - i);
      end
    end
  end

endmodule

// File: rtl/zero_count_seq.sv
// Multi-cycle leading/trailing zero counter with valid/ready handshakes,
// scanning CHUNK bits per clock and stopping at the first set bit.
module zero_count_seq
  import zero_count_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] vec,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             all_zero
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LCW = $clog2(CHUNK + 1);
  localparam logic [KW-1:0] LAST = KW'(NCH - 1);

  generate
    if ((WIDTH % CHUNK) != 0 || WIDTH < 2 || CHUNK < 1) begin : g_bad_cfg
      $error("zero_count_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_vec;
  logic             r_mode;
  logic [KW-1:0]    r_k;
  logic [KW-1:0]    r_ck;
  logic [CHUNK-1:0] r_chunk;
  logic             r_cvalid;
  logic [CW-1:0]    r_count;
  logic             r_all_zero;
  logic [CHUNK-1:0] w_fetch;
  logic             w_found;
  logic [LCW-1:0]   w_lcnt;
  logic [CW-1:0]    w_total;
  logic             w_accept;
  logic             w_eval_last;

  // Chunk k is fetched into r_chunk one cycle and evaluated the next,
  // keeping the wide select mux apart from the priority/count logic.
  always_comb begin
    w_fetch = '0;
    for (int unsigned j = 0; j < NCH; j++) begin
      if (r_k == KW'(j)) begin
        if (r_mode == MODE_LEAD) w_fetch = r_vec[WIDTH-1-j*CHUNK -: CHUNK];
        else                     w_fetch = r_vec[j*CHUNK +: CHUNK];
      end
    end
  end

  chunk_zero_count #(.CHUNK(CHUNK)) u_chunk (
    .chunk  (r_chunk),
    .mode   (r_mode),
    .found  (w_found),
    .zcount (w_lcnt)
  );

  assign w_total     = CW'(r_ck * CHUNK) + CW'(w_lcnt);
  assign w_accept    = (r_state == IDLE) && in_valid;
  assign w_eval_last = (r_ck == LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = SCAN;
      SCAN:    if (r_cvalid && (w_found || w_eval_last)) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec      <= '0;
      r_mode     <= MODE_TRAIL;
      r_k        <= '0;
      r_ck       <= '0;
      r_chunk    <= '0;
      r_cvalid   <= 1'b0;
      r_count    <= '0;
      r_all_zero <= 1'b0;
    end else if (w_accept) begin
      r_vec    <= vec;
      r_mode   <= mode;
      r_k      <= '0;
      r_cvalid <= 1'b0;
    end else if (r_state == SCAN) begin
      r_chunk  <= w_fetch;
      r_ck     <= r_k;
      r_cvalid <= 1'b1;
      if (r_k != LAST) r_k <= r_k + 1'b1;
      if (r_cvalid) begin
        if (w_found) begin
          r_count    <= w_total;
          r_all_zero <= 1'b0;
        end else if (w_eval_last) begin
          r_count    <= CW'(WIDTH);
          r_all_zero <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign count     = r_count;
  assign all_zero  = r_all_zero;

endmodule

// File: tb/tb_zero_count_seq.sv
// Directed and randomised checks of zero_count_seq across four configurations.
module tb_zero_count_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv_a  [4];
  logic        or_a  [4];
  logic [31:0] vec_a [4];
  logic        mode_a[4];
  logic        ir_a  [4];
  logic        ov_a  [4];
  logic [5:0]  cnt_a [4];
  logic        az_a  [4];
  logic [4:0]  cnt16;

  int cfg_w[4] = '{32, 16, 32, 32};
  int cfg_c[4] = '{8, 1, 4, 32};

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  zero_count_seq #(.WIDTH(32), .CHUNK(8)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a[0]), .in_ready(ir_a[0]),
    .vec(vec_a[0]), .mode(mode_a[0]), .out_valid(ov_a[0]), .out_ready(or_a[0]),
    .count(cnt_a[0]), .all_zero(az_a[0]));

  zero_count_seq #(.WIDTH(16), .CHUNK(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a[1]), .in_ready(ir_a[1]),
    .vec(vec_a[1][15:0]), .mode(mode_a[1]), .out_valid(ov_a[1]), .out_ready(or_a[1]),
    .count(cnt16), .all_zero(az_a[1]));
  assign cnt_a[1] = {1'b0, cnt16};

  zero_count_seq #(.WIDTH(32), .CHUNK(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a[2]), .in_ready(ir_a[2]),
    .vec(vec_a[2]), .mode(mode_a[2]), .out_valid(ov_a[2]), .out_ready(or_a[2]),
    .count(cnt_a[2]), .all_zero(az_a[2]));

  zero_count_seq #(.WIDTH(32), .CHUNK(32)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a[3]), .in_ready(ir_a[3]),
    .vec(vec_a[3]), .mode(mode_a[3]), .out_valid(ov_a[3]), .out_ready(or_a[3]),
    .count(cnt_a[3]), .all_zero(az_a[3]));

  typedef struct {
    int          d;
    logic [31:0] v;
    logic        m;
    int          cnt;
    logic        az;
    int          lat;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Zeros counted in scan order: bit i from the LSB, or bit w-1-i from the MSB.
  function automatic int model_zc(logic [31:0] v, int w, logic m);
    for (int i = 0; i < w; i++) begin
      int b;
      b = m ? (w - 1 - i) : i;
      if (v[b]) return i;
    end
    return w;
  endfunction

  function automatic int model_lat(int cnt, int w, int c);
    int n;
    n = (cnt < w) ? (cnt / c + 1) : (w / c);
    return n + 1;
  endfunction

  task automatic transact(input int d, input logic [31:0] v, input logic m,
                          input int ecnt, input logic eaz, input int elat,
                          input string tag);
    int t;
    int lat;
    t = 0;
    while (!ir_a[d] && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) chk({tag, " in_ready wait"}, 0, 1);
    vec_a[d]  = v;
    mode_a[d] = m;
    iv_a[d]   = 1'b1;
    or_a[d]   = 1'b1;
    @(posedge clk); #1;
    iv_a[d]   = 1'b0;
    vec_a[d]  = ~v;
    mode_a[d] = ~m;
    lat = 0;
    while (!ov_a[d] && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, " latency"}, lat, elat);
    chk({tag, " count"}, int'(cnt_a[d]), ecnt);
    chk({tag, " all_zero"}, int'(az_a[d]), int'(eaz));
    @(posedge clk); #1;
    chk({tag, " in_ready after consume"}, int'(ir_a[d]), 1);
  endtask

  task automatic rand_run(input int d, input int n);
    logic [31:0] v;
    logic        m;
    int          e;
    for (int i = 0; i < n; i++) begin
      v = $urandom();
      case ($urandom_range(0, 3))
        0: v = v >> $urandom_range(0, 31);
        1: v = v << $urandom_range(0, 31);
        2: v = v & (v >> 1) & (v << 1);
        default: ;
      endcase
      if ($urandom_range(0, 15) == 0) v = '0;
      if (cfg_w[d] == 16) v = v & 32'h0000_FFFF;
      m = 1'($urandom_range(0, 1));
      e = model_zc(v, cfg_w[d], m);
      transact(d, v, m, e, (e == cfg_w[d]), model_lat(e, cfg_w[d], cfg_c[d]),
               $sformatf("rnd d%0d #%0d v=%08h m=%0d", d, i, v, m));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int d = 0; d < 4; d++) begin
      iv_a[d] = 1'b0; or_a[d] = 1'b1; vec_a[d] = '0; mode_a[d] = 1'b0;
    end

    tbl[0]  = '{0, 32'h0000_0001, 1'b0,  0, 1'b0,  2};
    tbl[1]  = '{0, 32'h8000_0000, 1'b0, 31, 1'b0,  5};
    tbl[2]  = '{0, 32'h0001_0000, 1'b1, 15, 1'b0,  3};
    tbl[3]  = '{0, 32'h8000_0000, 1'b1,  0, 1'b0,  2};
    tbl[4]  = '{0, 32'h0000_0000, 1'b0, 32, 1'b1,  5};
    tbl[5]  = '{0, 32'h0000_0000, 1'b1, 32, 1'b1,  5};
    tbl[6]  = '{1, 32'h0000_0000, 1'b0, 16, 1'b1, 17};
    tbl[7]  = '{1, 32'h0000_0000, 1'b1, 16, 1'b1, 17};
    tbl[8]  = '{0, 32'h0000_0100, 1'b0,  8, 1'b0,  3};
    tbl[9]  = '{3, 32'h0000_0000, 1'b0, 32, 1'b1,  2};
    tbl[10] = '{3, 32'h8000_0000, 1'b0, 31, 1'b0,  2};
    tbl[11] = '{2, 32'h0000_0010, 1'b1, 27, 1'b0,  8};
    tbl[12] = '{1, 32'h0000_8000, 1'b0, 15, 1'b0, 17};
    tbl[13] = '{2, 32'h0000_0100, 1'b0,  8, 1'b0,  4};

    rst_n = 1'b0;
    #12;
    chk("reset in_ready", int'(ir_a[0]), 1);
    chk("reset out_valid", int'(ov_a[0]), 0);
    chk("reset count", int'(cnt_a[0]), 0);
    chk("reset all_zero", int'(az_a[0]), 0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      transact(tbl[i].d, tbl[i].v, tbl[i].m, tbl[i].cnt, tbl[i].az, tbl[i].lat,
               $sformatf("tbl[%0d]", i));
    end

    // Backpressure: result held in DONE while inputs churn.
    vec_a[0] = 32'h0000_4000; mode_a[0] = 1'b0; iv_a[0] = 1'b1; or_a[0] = 1'b0;
    @(posedge clk); #1;
    iv_a[0] = 1'b0;
    lat = 0;
    while (!ov_a[0] && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp latency", lat, 3);
    for (int c = 0; c < 10; c++) begin
      vec_a[0]  = $urandom();
      mode_a[0] = 1'($urandom_range(0, 1));
      iv_a[0]   = ~iv_a[0];
      @(posedge clk); #1;
      chk($sformatf("bp hold count c%0d", c), int'(cnt_a[0]), 14);
      chk($sformatf("bp hold out_valid c%0d", c), int'(ov_a[0]), 1);
      chk($sformatf("bp hold in_ready c%0d", c), int'(ir_a[0]), 0);
    end
    vec_a[0] = 32'h0000_0001; iv_a[0] = 1'b1; or_a[0] = 1'b1;
    @(posedge clk); #1;
    iv_a[0] = 1'b0;
    chk("bp consumed out_valid", int'(ov_a[0]), 0);
    chk("bp no accept at handshake", int'(ir_a[0]), 1);
    @(posedge clk); #1;
    chk("bp idle after handshake", int'(ir_a[0]), 1);

    // Reset in the middle of a scan drops the operation.
    vec_a[0] = 32'h0010_0000; mode_a[0] = 1'b0; iv_a[0] = 1'b1;
    @(posedge clk); #1;
    iv_a[0] = 1'b0;
    @(posedge clk); #1;
    chk("midscan busy", int'(ir_a[0]), 0);
    rst_n = 1'b0;
    #1;
    chk("midscan rst in_ready", int'(ir_a[0]), 1);
    chk("midscan rst out_valid", int'(ov_a[0]), 0);
    chk("midscan rst count", int'(cnt_a[0]), 0);
    chk("midscan rst all_zero", int'(az_a[0]), 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    transact(0, 32'h0000_0100, 1'b0, 8, 1'b0, 3, "post-reset");

    fork
      rand_run(0, 6000);
      rand_run(1, 2000);
      rand_run(2, 5000);
      rand_run(3, 7000);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
